// File: rtl/decode_logic.sv
// Receive-side packet decoder: recovers a 29-bit node packet from a 55-bit link packet,
// decoding one 3-of-6 symbol or one checksum nibble per cycle.
module decode_logic #(
  parameter bit CHECK_PAD = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [54:0] packet_in,
  input  logic        packet_valid,
  output logic        packet_ready,
  output logic [28:0] Packet_To_Node,
  output logic        node_valid,
  input  logic        node_ready,
  output logic        decode_err,
  output logic [1:0]  err_code
);

  localparam int unsigned PKT_W  = 55;
  localparam int unsigned NODE_W = 29;
  localparam int unsigned PAY_W  = 24;

  localparam logic [2:0] TYPE_3OF6 = 3'b001;
  localparam logic [2:0] TYPE_CSUM = 3'b010;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_SYM  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TYPE = 2'd3;

  typedef enum logic [1:0] {IDLE, DECODE, DONE} state_e;

  state_e             state_q, state_d;
  logic [PKT_W-1:0]   pkt_q, pkt_d;
  logic [PAY_W-1:0]   payload_q, payload_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [3:0]         sum_q, sum_d;
  logic               bad_q, bad_d;
  logic [NODE_W-1:0]  out_q, out_d;
  logic [1:0]         err_code_q, err_code_d;
  logic               node_valid_q, packet_ready_q, decode_err_q;

  logic [5:0] sym_base_c, nib_base_c;
  logic [4:0] pay_base_c;
  logic [5:0] sym_c;
  logic [3:0] nib_c;
  logic [3:0] sym_dec_c;
  logic       pad_bad_c;

  // {valid, value} for one 3-of-6 codeword; invalid codewords decode as 000
  function automatic logic [3:0] sym_decode(input logic [5:0] cw);
    case (cw)
      6'b000111: sym_decode = 4'b1_000;
      6'b001011: sym_decode = 4'b1_001;
      6'b001101: sym_decode = 4'b1_010;
      6'b001110: sym_decode = 4'b1_011;
      6'b010011: sym_decode = 4'b1_100;
      6'b010101: sym_decode = 4'b1_101;
      6'b010110: sym_decode = 4'b1_110;
      6'b011001: sym_decode = 4'b1_111;
      default:   sym_decode = 4'b0_000;
    endcase
  endfunction

  assign sym_base_c = 6'(cnt_q) * 6'd6;
  assign nib_base_c = 6'd24 + {1'b0, cnt_q, 2'b00};
  assign pay_base_c = 5'(cnt_q) * 5'd3;
  assign sym_c      = pkt_q[sym_base_c +: 6];
  assign nib_c      = pkt_q[nib_base_c +: 4];
  assign sym_dec_c  = sym_decode(sym_c);
  assign pad_bad_c  = CHECK_PAD && (pkt_q[19:0] != 20'd0);

  // Next-state and datapath
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    payload_d  = payload_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    bad_d      = bad_q;
    out_d      = out_q;
    err_code_d = err_code_q;

    case (state_q)
      IDLE: begin
        if (packet_valid) begin
          pkt_d     = packet_in;
          payload_d = '0;
          cnt_d     = 3'd0;
          sum_d     = 4'd0;
          bad_d     = 1'b0;
          if (packet_in[54:52] == TYPE_3OF6 || packet_in[54:52] == TYPE_CSUM) begin
            state_d = DECODE;
          end else begin
            state_d    = DONE;
            out_d      = {packet_in[51:48], 1'b0, 24'd0};
            err_code_d = ERR_TYPE;
          end
        end
      end
      DECODE: begin
        cnt_d = cnt_q + 3'd1;
        if (pkt_q[54:52] == TYPE_3OF6) begin
          payload_d[pay_base_c +: 3] = sym_dec_c[2:0];
          bad_d = bad_q | ~sym_dec_c[3];
          if (cnt_q == 3'd7) begin
            state_d    = DONE;
            out_d      = {pkt_q[51:48], 1'b1, payload_d};
            err_code_d = bad_d ? ERR_SYM : ERR_NONE;
          end
        end else begin
          sum_d = sum_q + nib_c;
          if (cnt_q == 3'd5) begin
            state_d    = DONE;
            out_d      = {pkt_q[51:48], 1'b0, pkt_q[47:24]};
            err_code_d = (sum_d != pkt_q[23:20] || pad_bad_c) ? ERR_CSUM : ERR_NONE;
          end
        end
      end
      DONE: begin
        if (node_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pkt_q          <= '0;
      payload_q      <= '0;
      cnt_q          <= 3'd0;
      sum_q          <= 4'd0;
      bad_q          <= 1'b0;
      out_q          <= '0;
      err_code_q     <= ERR_NONE;
      decode_err_q   <= 1'b0;
      node_valid_q   <= 1'b0;
      packet_ready_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      pkt_q          <= pkt_d;
      payload_q      <= payload_d;
      cnt_q          <= cnt_d;
      sum_q          <= sum_d;
      bad_q          <= bad_d;
      out_q          <= out_d;
      err_code_q     <= err_code_d;
      decode_err_q   <= (err_code_d != ERR_NONE);
      node_valid_q   <= (state_d == DONE);
      packet_ready_q <= (state_d == IDLE);
    end
  end

  assign packet_ready   = packet_ready_q;
  assign node_valid     = node_valid_q;
  assign Packet_To_Node = out_q;
  assign err_code       = err_code_q;
  assign decode_err     = decode_err_q;

endmodule

// File: tb/tb_decode_logic.sv
// Directed, table-driven bench for decode_logic with hand-sequenced backpressure and reset cases.
module tb_decode_logic;

  logic        clk = 1'b0;
  logic        rst;
  logic [54:0] packet_in;
  logic        packet_valid;
  logic        packet_ready;
  logic [28:0] Packet_To_Node;
  logic        node_valid;
  logic        node_ready;
  logic        decode_err;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_fail   = 0;

  decode_logic #(.CHECK_PAD(1'b1)) dut (
    .clk(clk), .rst(rst), .packet_in(packet_in), .packet_valid(packet_valid),
    .packet_ready(packet_ready), .Packet_To_Node(Packet_To_Node), .node_valid(node_valid),
    .node_ready(node_ready), .decode_err(decode_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [54:0] pkt;
    int          lat;
    logic [28:0] out;
    logic [1:0]  err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] enc_sym(input logic [2:0] v);
    logic [5:0] map [8];
    map = '{6'b000111, 6'b001011, 6'b001101, 6'b001110,
            6'b010011, 6'b010101, 6'b010110, 6'b011001};
    return map[v];
  endfunction

  function automatic logic [54:0] enc36(input logic [3:0] addr, input logic [23:0] pay);
    logic [47:0] body;
    for (int k = 0; k < 8; k++) body[6*k +: 6] = enc_sym(pay[3*k +: 3]);
    return {3'b001, addr, body};
  endfunction

  function automatic logic [3:0] nsum(input logic [23:0] pay);
    logic [3:0] s = 4'd0;
    for (int k = 0; k < 6; k++) s = s + pay[4*k +: 4];
    return s;
  endfunction

  function automatic logic [54:0] enccs(input logic [3:0] addr, input logic [23:0] pay,
                                        input logic [3:0] ck, input logic [19:0] pad);
    return {3'b010, addr, pay, ck, pad};
  endfunction

  // Apply one packet with node_ready high; verify latency, outputs, busy window and return to IDLE
  task automatic run_pkt(input vec_t v);
    int lat;
    check({v.name, " ready_before"}, 32'(packet_ready), 32'd1);
    packet_in    = v.pkt;
    packet_valid = 1'b1;
    node_ready   = 1'b1;
    @(posedge clk); #1;
    packet_valid = 1'b0;
    lat = 1;
    while (!node_valid && lat < 40) begin
      if (packet_ready !== 1'b0) begin
        n_checks++; n_fail++;
        $display("FAIL %s busy_ready: got %b expected 0 at cycle %0d", v.name, packet_ready, lat);
      end
      @(posedge clk); #1;
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " out"}, 32'(Packet_To_Node), 32'(v.out));
    check({v.name, " err_code"}, 32'(err_code), 32'(v.err));
    check({v.name, " decode_err"}, 32'(decode_err), 32'(v.err != 2'd0));
    check({v.name, " ready_in_done"}, 32'(packet_ready), 32'd0);
    @(posedge clk); #1;
    check({v.name, " idle_ready"}, 32'(packet_ready), 32'd1);
    check({v.name, " idle_valid"}, 32'(node_valid), 32'd0);
  endtask

  vec_t vecs [$];

  initial begin
    logic [54:0] p;
    logic [28:0] held;
    vec_t v;
    int lat;

    rst = 1'b1; packet_in = '0; packet_valid = 1'b0; node_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset ready", 32'(packet_ready), 32'd1);
    check("reset valid", 32'(node_valid), 32'd0);
    check("reset out", 32'(Packet_To_Node), 32'd0);
    check("reset err", 32'({decode_err, err_code}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    p = enc36(4'h7, 24'hA5C3F0);
    vecs.push_back('{"36_clean", p, 9, {4'h7, 1'b1, 24'hA5C3F0}, 2'd0});
    p[23:18] = 6'b111000;
    vecs.push_back('{"36_bad_sym3", p, 9, {4'h7, 1'b1, 24'hA5C1F0}, 2'd1});
    p = enc36(4'hC, 24'hFFFFFF);
    p[5:0] = 6'b000000; p[47:42] = 6'b111111;
    vecs.push_back('{"36_bad_two", p, 9, {4'hC, 1'b1, 24'h1FFFF8}, 2'd1});
    vecs.push_back('{"36_zero", enc36(4'h0, 24'h000000), 9, {4'h0, 1'b1, 24'h000000}, 2'd0});
    vecs.push_back('{"cs_ok", enccs(4'h2, 24'h123456, 4'h5, 20'h0), 7, {4'h2, 1'b0, 24'h123456}, 2'd0});
    vecs.push_back('{"cs_bad_sum", enccs(4'h2, 24'h123456, 4'h6, 20'h0), 7, {4'h2, 1'b0, 24'h123456}, 2'd2});
    vecs.push_back('{"cs_bad_pad", enccs(4'h2, 24'h123456, 4'h5, 20'h1), 7, {4'h2, 1'b0, 24'h123456}, 2'd2});
    vecs.push_back('{"cs_wrap", enccs(4'hF, 24'hFFFFFF, 4'hA, 20'h0), 7, {4'hF, 1'b0, 24'hFFFFFF}, 2'd0});
    vecs.push_back('{"unknown", {3'b111, 4'h9, 48'hDEAD_BEEF_0123}, 1, {4'h9, 1'b0, 24'h0}, 2'd3});
    vecs.push_back('{"unknown0", {3'b000, 4'h3, 48'h0}, 1, {4'h3, 1'b0, 24'h0}, 2'd3});

    foreach (vecs[i]) run_pkt(vecs[i]);

    // Backpressure in DONE while the next packet is already offered
    packet_in = enccs(4'h2, 24'h123456, 4'h5, 20'h0);
    packet_valid = 1'b1; node_ready = 1'b0;
    @(posedge clk); #1;
    packet_in = {3'b101, 4'h4, 48'h0};
    lat = 1;
    while (!node_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    check("bp latency", 32'(lat), 32'd7);
    held = 29'({4'h2, 1'b0, 24'h123456});
    for (int c = 0; c < 5; c++) begin
      check("bp valid", 32'(node_valid), 32'd1);
      check("bp out", 32'(Packet_To_Node), 32'(held));
      check("bp err", 32'(err_code), 32'd0);
      check("bp ready", 32'(packet_ready), 32'd0);
      @(posedge clk); #1;
    end
    node_ready = 1'b1;
    @(posedge clk); #1;
    check("bp handshake ready", 32'(packet_ready), 32'd1);
    check("bp handshake valid", 32'(node_valid), 32'd0);
    @(posedge clk); #1;
    packet_valid = 1'b0;
    check("b2b second valid", 32'(node_valid), 32'd1);
    check("b2b second err", 32'(err_code), 32'd3);
    check("b2b second out", 32'(Packet_To_Node), 32'({4'h4, 1'b0, 24'h0}));
    @(posedge clk); #1;

    // Reset in the middle of a 3-of-6 decode
    packet_in = enc36(4'h7, 24'hA5C3F0);
    packet_valid = 1'b1; node_ready = 1'b1;
    @(posedge clk); #1;
    packet_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst valid", 32'(node_valid), 32'd0);
    check("mid_rst err", 32'(err_code), 32'd0);
    check("mid_rst ready", 32'(packet_ready), 32'd1);
    check("mid_rst out", 32'(Packet_To_Node), 32'd0);
    v = '{"post_rst", enc36(4'h5, 24'h0F1E2D), 9, {4'h5, 1'b1, 24'h0F1E2D}, 2'd0};
    run_pkt(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
